// File: rtl/sha3_digest_streamer.sv
// sha3_digest_streamer: captures the Keccak state on state_valid, keeps the
// SHA3-256 (lanes 0..3) or SHA3-512 (lanes 0..7) digest and streams it as an
// AXI-Stream master, DATA_WIDTH bits per beat, little-endian within each lane.
// Optional feature macro: SHA3_DROP_CNT_EN adds a saturating drop_cnt output.
module sha3_digest_streamer #(
   parameter int DATA_WIDTH = 16,
   parameter int ID_WIDTH   = 8
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic                      state_valid,
   input  logic [4:0][4:0][63:0]     state_in,
   input  logic                      mode,
   input  logic [ID_WIDTH-1:0]       id_in,
   output logic [DATA_WIDTH-1:0]     M_TDATA,
   output logic                      M_TVALID,
   input  logic                      M_TREADY,
   output logic                      M_TLAST,
   output logic [DATA_WIDTH/8-1:0]   M_TKEEP,
   output logic [ID_WIDTH-1:0]       M_TID,
   output logic                      busy,
   output logic                      drop
`ifdef SHA3_DROP_CNT_EN
   ,output logic [15:0]              drop_cnt
`endif
);

   localparam int NMAX = 512 / DATA_WIDTH;
   localparam int CW   = $clog2(NMAX);
   localparam logic [CW-1:0] LAST256 = CW'(256 / DATA_WIDTH - 1);
   localparam logic [CW-1:0] LAST512 = CW'(NMAX - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                             state;
   logic [NMAX-1:0][DATA_WIDTH-1:0]    dig;      // digest viewed as stream words
   logic [NMAX-1:0][DATA_WIDTH-1:0]    cap_dig;
   logic [CW-1:0]                      cnt;
   logic [CW-1:0]                      cnt_nx;
   logic                               mode_r;
   logic                               hs;
   logic                               last_hs;
   logic                               capture;
   logic                               discard;
   logic                               unused_lanes;

   // Linear lane i = x + 5*y; lane 0 sits in the low bits so word k is
   // simply the k-th DATA_WIDTH slice of the concatenation.
   assign cap_dig = {state_in[2][1], state_in[1][1], state_in[0][1],
                     state_in[4][0], state_in[3][0], state_in[2][0],
                     state_in[1][0], state_in[0][0]};

   // Lanes beyond the 512-bit digest are never stored.
   assign unused_lanes = ^{state_in[3][1], state_in[4][1],
                           state_in[0][4:2], state_in[1][4:2], state_in[2][4:2],
                           state_in[3][4:2], state_in[4][4:2]};

   assign hs      = M_TVALID & M_TREADY;
   assign last_hs = hs & M_TLAST;
   // A new state is taken when idle, or back-to-back with the final beat.
   assign capture = state_valid & ((state == IDLE) | last_hs);
   assign discard = state_valid & ~capture;
   assign cnt_nx  = cnt + 1'b1;
   assign M_TKEEP = {(DATA_WIDTH/8){M_TVALID}};

   // Capture / stream FSM with registered outputs.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state    <= IDLE;
         dig      <= '0;
         cnt      <= '0;
         mode_r   <= 1'b0;
         M_TDATA  <= '0;
         M_TVALID <= 1'b0;
         M_TLAST  <= 1'b0;
         M_TID    <= '0;
         busy     <= 1'b0;
         drop     <= 1'b0;
      end else begin
         drop <= discard;
         if (capture) begin
            state    <= SEND;
            busy     <= 1'b1;
            dig      <= cap_dig;
            mode_r   <= mode;
            M_TID    <= id_in;
            cnt      <= '0;
            M_TDATA  <= cap_dig[0];
            M_TVALID <= 1'b1;
            M_TLAST  <= 1'b0;         // every digest has at least four words
         end else if (last_hs) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
            M_TVALID <= 1'b0;
            M_TLAST  <= 1'b0;
         end else if (hs) begin
            cnt      <= cnt_nx;
            M_TDATA  <= dig[cnt_nx];
            M_TLAST  <= (cnt_nx == (mode_r ? LAST512 : LAST256));
         end
      end
   end

`ifdef SHA3_DROP_CNT_EN
   // Saturating count of discarded captures.
   always_ff @(posedge ACLK) begin
      if (ARESET)
         drop_cnt <= '0;
      else if (drop && drop_cnt != 16'hFFFF)
         drop_cnt <= drop_cnt + 16'd1;
   end
`endif

endmodule
